// File: rtl/control_multiciclo.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// produces datapath strobes, detects illegal opcodes and memory timeouts, and
// counts retired instructions.
module control_multiciclo #(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit HALT_ON_LOOP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error,
    output logic [31:0] instr_retired
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] LOOP_INSTR = 32'hfe000ee3;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_q;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc;
    logic              retire;
    logic              set_illegal;
    logic              set_bus_error;
    logic [6:0]        opcode;
    logic              opcode_legal;
    logic              is_store;
    logic              timeout;

    assign opcode    = instruction[6:0];
    assign is_store  = (opcode == OP_STORE);
    assign timeout   = (wait_cnt == WAIT_LAST);
    assign state     = state_q;
    assign halted    = (state_q == HALT);

    // Opcode whitelist checked in DECODE; anything else is treated as illegal
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
            default: opcode_legal = 1'b0;
        endcase
    end

    // Next-state and strobe decode; strobes forced low while reset is held
    always_comb begin
        state_next    = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        alu_src_b     = 1'b0;
        alu_op        = 2'b00;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        wait_inc      = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    set_bus_error = 1'b1;
                    state_next    = HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            DECODE: begin
                if (HALT_ON_LOOP && (instruction == LOOP_INSTR)) begin
                    state_next = HALT;
                end else if (!opcode_legal) begin
                    set_illegal = 1'b1;
                    state_next  = HALT;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                case (opcode)
                    OP_R: begin
                        alu_op     = 2'b10;
                        alu_src_b  = 1'b0;
                        state_next = WRITEBACK;
                    end
                    OP_I: begin
                        alu_op     = 2'b10;
                        alu_src_b  = 1'b1;
                        state_next = WRITEBACK;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op     = 2'b00;
                        alu_src_b  = 1'b1;
                        state_next = MEMORY;
                    end
                    OP_BRANCH: begin
                        alu_op     = 2'b01;
                        alu_src_b  = 1'b0;
                        pc_write   = 1'b1;
                        pc_src     = branch_taken ? 2'd1 : 2'd0;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: begin
                        alu_op     = 2'b00;
                        alu_src_b  = 1'b1;
                        state_next = WRITEBACK;
                    end
                endcase
            end
            MEMORY: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        pc_src     = 2'd0;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WRITEBACK;
                    end
                end else if (timeout) begin
                    set_bus_error = 1'b1;
                    state_next    = HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
                if (opcode == OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
                    wb_sel = 2'd2;
                end
                if (opcode == OP_JAL) begin
                    pc_src = 2'd1;
                end else if (opcode == OP_JALR) begin
                    pc_src = 2'd2;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase

        if (!reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            reg_write = 1'b0;
            wb_sel    = 2'd0;
            alu_src_b = 1'b0;
            alu_op    = 2'b00;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Consecutive wait-cycle counter; any ready or state change restarts it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky halt-cause flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            illegal   <= illegal | set_illegal;
            bus_error <= bus_error | set_bus_error;
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_retired <= 32'd0;
        end else if (retire) begin
            instr_retired <= instr_retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed self-checking bench for control_multiciclo.
module tb_control_multiciclo;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic        bus_error;
    logic [31:0] instr_retired;

    int errors = 0;
    int checks = 0;

    logic [11:0] strb;
    assign strb = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, alu_src_b, alu_op};

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000a103;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_SW   = 32'h0020a023;
    localparam logic [31:0] I_JAL  = 32'h008000ef;
    localparam logic [31:0] I_JALR = 32'h000080e7;
    localparam logic [31:0] I_LOOP = 32'hfe000ee3;
    localparam logic [31:0] I_BAD  = 32'h0000007f;

    typedef struct packed {
        logic [31:0] ins;
        logic        bt;
        logic        rdy;
        logic [2:0]  st;
        logic [11:0] sv;
    } row_t;

    control_multiciclo #(.MEM_TIMEOUT(16), .HALT_ON_LOOP(1'b1)) dut (
        .clock(clock), .reset(reset), .instruction(instruction),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .wb_sel(wb_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .halted(halted), .illegal(illegal),
        .bus_error(bus_error), .instr_retired(instr_retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] s(input logic req, input logic we, input logic irw, input logic pcw,
                                      input logic [1:0] pcs, input logic rw, input logic [1:0] wb,
                                      input logic asb, input logic [1:0] aop);
        return {req, we, irw, pcw, pcs, rw, wb, asb, aop};
    endfunction

    function automatic row_t r(input logic [31:0] ins, input logic bt, input logic rdy,
                               input logic [2:0] st, input logic [11:0] sv);
        row_t x;
        x.ins = ins; x.bt = bt; x.rdy = rdy; x.st = st; x.sv = sv;
        return x;
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        #3;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({state, strb, halted, illegal, bus_error, instr_retired} !== {S_F, 12'd0, 3'b000, 32'd0}) begin
            errors++;
            $display("FAIL reset_hold: got st=%0d strb=%h h/i/b=%b%b%b ret=%0d expected st=0 strb=000 000 ret=0",
                     state, strb, halted, illegal, bus_error, instr_retired);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({state, strb} !== {S_F, s(1,0,0,0,2'd0,0,2'd0,0,2'd0)}) begin
            errors++;
            $display("FAIL reset_release: got st=%0d strb=%h expected st=0 strb=%h", state, strb, s(1,0,0,0,2'd0,0,2'd0,0,2'd0));
        end
    endtask

    task automatic test_addi();
        row_t seq [4];
        seq = '{r(I_ADDI,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_ADDI,0,1,S_D,12'd0),
                r(I_ADDI,0,1,S_E,s(0,0,0,0,2'd0,0,2'd0,1,2'b10)),
                r(I_ADDI,0,1,S_W,s(0,0,0,1,2'd0,1,2'd0,0,2'b00))};
        for (int i = 0; i < 4; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL addi[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        checks++;
        if ({state, instr_retired} !== {S_F, 32'd1}) begin
            errors++;
            $display("FAIL addi_retire: got st=%0d ret=%0d expected st=0 ret=1", state, instr_retired);
        end
    endtask

    task automatic test_load_wait();
        row_t seq [8];
        seq = '{r(I_LW,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_LW,0,1,S_D,12'd0),
                r(I_LW,0,1,S_E,s(0,0,0,0,2'd0,0,2'd0,1,2'b00)),
                r(I_LW,0,0,S_M,s(1,0,0,0,2'd0,0,2'd0,0,2'd0)),
                r(I_LW,0,0,S_M,s(1,0,0,0,2'd0,0,2'd0,0,2'd0)),
                r(I_LW,0,0,S_M,s(1,0,0,0,2'd0,0,2'd0,0,2'd0)),
                r(I_LW,0,1,S_M,s(1,0,0,0,2'd0,0,2'd0,0,2'd0)),
                r(I_LW,0,1,S_W,s(0,0,0,1,2'd0,1,2'd1,0,2'd0))};
        for (int i = 0; i < 8; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL load[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        checks++;
        if ({state, instr_retired} !== {S_F, 32'd2}) begin
            errors++;
            $display("FAIL load_retire: got st=%0d ret=%0d expected st=0 ret=2", state, instr_retired);
        end
    endtask

    task automatic test_branch();
        row_t seq [6];
        seq = '{r(I_BEQ,1,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_BEQ,1,1,S_D,12'd0),
                r(I_BEQ,1,1,S_E,s(0,0,0,1,2'd1,0,2'd0,0,2'b01)),
                r(I_BEQ,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_BEQ,0,1,S_D,12'd0),
                r(I_BEQ,0,1,S_E,s(0,0,0,1,2'd0,0,2'd0,0,2'b01))};
        for (int i = 0; i < 6; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL branch[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        checks++;
        if ({state, instr_retired} !== {S_F, 32'd4}) begin
            errors++;
            $display("FAIL branch_retire: got st=%0d ret=%0d expected st=0 ret=4", state, instr_retired);
        end
    endtask

    task automatic test_store();
        row_t seq [4];
        seq = '{r(I_SW,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_SW,0,1,S_D,12'd0),
                r(I_SW,0,1,S_E,s(0,0,0,0,2'd0,0,2'd0,1,2'b00)),
                r(I_SW,0,1,S_M,s(1,1,0,1,2'd0,0,2'd0,0,2'd0))};
        for (int i = 0; i < 4; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL store[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        checks++;
        if ({state, instr_retired} !== {S_F, 32'd5}) begin
            errors++;
            $display("FAIL store_retire: got st=%0d ret=%0d expected st=0 ret=5", state, instr_retired);
        end
    endtask

    task automatic test_jumps();
        row_t seq [8];
        seq = '{r(I_JAL,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_JAL,0,1,S_D,12'd0),
                r(I_JAL,0,1,S_E,s(0,0,0,0,2'd0,0,2'd0,1,2'b00)),
                r(I_JAL,0,1,S_W,s(0,0,0,1,2'd1,1,2'd2,0,2'd0)),
                r(I_JALR,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_JALR,0,1,S_D,12'd0),
                r(I_JALR,0,1,S_E,s(0,0,0,0,2'd0,0,2'd0,1,2'b00)),
                r(I_JALR,0,1,S_W,s(0,0,0,1,2'd2,1,2'd2,0,2'd0))};
        for (int i = 0; i < 8; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL jump[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        checks++;
        if ({state, instr_retired} !== {S_F, 32'd7}) begin
            errors++;
            $display("FAIL jump_retire: got st=%0d ret=%0d expected st=0 ret=7", state, instr_retired);
        end
    endtask

    task automatic test_halt_loop();
        row_t seq [3];
        seq = '{r(I_LOOP,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_LOOP,0,1,S_D,12'd0),
                r(I_LOOP,0,1,S_H,12'd0)};
        for (int i = 0; i < 3; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL loop[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({state, strb, halted, illegal, bus_error, instr_retired} !== {S_H, 12'd0, 3'b100, 32'd7}) begin
            errors++;
            $display("FAIL loop_halt: got st=%0d strb=%h h/i/b=%b%b%b ret=%0d expected st=5 strb=000 100 ret=7",
                     state, strb, halted, illegal, bus_error, instr_retired);
        end
    endtask

    task automatic test_reset_mid_store();
        row_t seq [7];
        apply_reset();
        seq = '{r(I_ADDI,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_ADDI,0,1,S_D,12'd0),
                r(I_ADDI,0,1,S_E,s(0,0,0,0,2'd0,0,2'd0,1,2'b10)),
                r(I_ADDI,0,1,S_W,s(0,0,0,1,2'd0,1,2'd0,0,2'b00)),
                r(I_SW,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_SW,0,1,S_D,12'd0),
                r(I_SW,0,1,S_E,s(0,0,0,0,2'd0,0,2'd0,1,2'b00))};
        for (int i = 0; i < 7; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL midrst[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, mem_req, mem_we, instr_retired} !== {S_M, 2'b11, 32'd1}) begin
            errors++;
            $display("FAIL midrst_mem: got st=%0d req=%b we=%b ret=%0d expected st=3 req=1 we=1 ret=1",
                     state, mem_req, mem_we, instr_retired);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({state, strb, instr_retired} !== {S_F, 12'd0, 32'd0}) begin
            errors++;
            $display("FAIL midrst_drop: got st=%0d strb=%h ret=%0d expected st=0 strb=000 ret=0", state, strb, instr_retired);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_illegal();
        row_t seq [3];
        apply_reset();
        seq = '{r(I_BAD,0,1,S_F,s(1,0,1,0,2'd0,0,2'd0,0,2'd0)),
                r(I_BAD,0,1,S_D,12'd0),
                r(I_BAD,0,1,S_H,12'd0)};
        for (int i = 0; i < 3; i++) begin
            instruction = seq[i].ins; branch_taken = seq[i].bt; mem_ready = seq[i].rdy;
            #1;
            checks++;
            if ({state, strb} !== {seq[i].st, seq[i].sv}) begin
                errors++;
                $display("FAIL illegal[%0d]: got st=%0d strb=%h expected st=%0d strb=%h", i, state, strb, seq[i].st, seq[i].sv);
            end
            @(posedge clock); #1;
        end
        checks++;
        if ({state, halted, illegal, bus_error, instr_retired} !== {S_H, 3'b110, 32'd0}) begin
            errors++;
            $display("FAIL illegal_flags: got st=%0d h/i/b=%b%b%b ret=%0d expected st=5 110 ret=0",
                     state, halted, illegal, bus_error, instr_retired);
        end
    endtask

    task automatic test_bus_error();
        instruction = I_ADDI;
        mem_ready = 1'b0;
        apply_reset();
        repeat (15) @(posedge clock);
        #1;
        checks++;
        if ({state, mem_req, bus_error} !== {S_F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL buserr_wait15: got st=%0d req=%b berr=%b expected st=0 req=1 berr=0", state, mem_req, bus_error);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({state, strb, halted, illegal, bus_error} !== {S_H, 12'd0, 3'b101}) begin
            errors++;
            $display("FAIL buserr_halt: got st=%0d strb=%h h/i/b=%b%b%b expected st=5 strb=000 101",
                     state, strb, halted, illegal, bus_error);
        end
        mem_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({state, strb, bus_error} !== {S_H, 12'd0, 1'b1}) begin
            errors++;
            $display("FAIL buserr_sticky: got st=%0d strb=%h berr=%b expected st=5 strb=000 berr=1", state, strb, bus_error);
        end
    endtask

    initial begin
        reset = 1'b1;
        instruction = 32'd0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        #2;
        test_reset();
        test_addi();
        test_load_wait();
        test_branch();
        test_store();
        test_jumps();
        test_halt_loop();
        test_reset_mid_store();
        test_illegal();
        test_bus_error();
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
